// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: drives the instruction memory and presents a registered
// instruction, its return address and a valid flag to decode.
module if_fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC_out,
  output logic        valid
);

  typedef enum logic [1:0] {
    ST_WAIT1 = 2'd0,
    ST_RUN   = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        imem_req_q;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_WAIT1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect always lands in RUN
  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_WAIT1: state_d = ST_RUN;
        ST_RUN: begin
          if (imem_ready && freeze) begin
            state_d = ST_SKID;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_SKID: begin
          if (!freeze) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: state_d = ST_WAIT1;
      endcase
    end
  end

  // Output and datapath next-state logic; everything holds unless a case updates it
  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (branch_taken) begin
      pc_d         = branch_addr & 32'hFFFF_FFFC;
      instr_d      = 32'd0;
      valid_d      = 1'b0;
      skid_instr_d = 32'd0;
      skid_pc_d    = 32'd0;
    end else begin
      case (state_q)
        ST_WAIT1: begin
          pc_d = pc_q;
        end
        ST_RUN: begin
          if (imem_ready) begin
            pc_d = pc_plus4(pc_q);
            if (freeze) begin
              // Decode is stalled: park the returned word until it can accept it.
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_plus4(pc_q);
            end else begin
              instr_d  = imem_rdata;
              pc_out_d = pc_plus4(pc_q);
              valid_d  = 1'b1;
            end
          end else if (!freeze) begin
            instr_d = 32'd0;
            valid_d = 1'b0;
          end else begin
            valid_d = valid_q;
          end
        end
        ST_SKID: begin
          if (!freeze) begin
            instr_d      = skid_instr_q;
            pc_out_d     = skid_pc_q;
            valid_d      = 1'b1;
            skid_instr_d = 32'd0;
            skid_pc_d    = 32'd0;
          end else begin
            valid_d = valid_q;
          end
        end
        default: begin
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= 32'd0;
      instr_q      <= 32'd0;
      pc_out_q     <= 32'd0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      imem_req_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      imem_req_q   <= (state_d == ST_RUN);
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign Instruction = instr_q;
  assign PC_out      = pc_out_q;
  assign valid       = valid_q;

endmodule
